// File: rtl/int_req_ctrl.sv
// Interrupt request controller: synchronises three request lines, latches edges
// as pending requests and drives fixed-priority entries. Nesting via INT_NEST_EN.
module int_req_ctrl #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] VEC_BASE     = 32'h0000_0100,
  parameter logic [WIDTH-1:0] VEC_STRIDE   = 32'h0000_0040,
  parameter int unsigned      GUARD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       irq,
  input  logic             ie,
  input  logic             en,
  input  logic             uret,
  output logic             Int_Enter,
  output logic [2:0]       IRS,
  output logic [WIDTH-1:0] int_vec,
  output logic [2:0]       pending,
  output logic [2:0]       in_service
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTER = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES);

  // One-hot of the highest set bit of v.
  function automatic logic [2:0] top_bit(input logic [2:0] v);
    top_bit = 3'b000;
    if (v[2])      top_bit = 3'b100;
    else if (v[1]) top_bit = 3'b010;
    else if (v[0]) top_bit = 3'b001;
  endfunction

  // Bits strictly above the highest set bit of v (all bits when v is empty).
  function automatic logic [2:0] above_mask(input logic [2:0] v);
    above_mask = 3'b111;
    if (v[2])      above_mask = 3'b000;
    else if (v[1]) above_mask = 3'b100;
    else if (v[0]) above_mask = 3'b110;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [2:0] v);
    onehot_idx = 2'd0;
    if (v[2])      onehot_idx = 2'd2;
    else if (v[1]) onehot_idx = 2'd1;
  endfunction

  logic [2:0] sync1_q, sync2_q, sync3_q;
  logic [1:0] settle_q;
  logic [2:0] rise;
  logic [2:0] eligible;
  logic [2:0] candidate;

  state_e     state_q, state_d;
  logic [2:0] irs_q, irs_d;
  logic [3:0] cnt_q, cnt_d;
  logic       int_enter_q, int_enter_d;
  logic [2:0] pending_q, pending_d;
  logic [2:0] in_service_q, in_service_d;
  logic [2:0] pend_clr;
  logic [2:0] is_set;

  // A line already high when reset releases is indistinguishable from a fresh
  // rise until sync3 holds a real sample, so detection waits three edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      sync3_q  <= 3'b000;
      settle_q <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its predecessor; blocking here would collapse the chain into one flop.
      sync1_q <= irq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  always_comb begin
    rise = sync2_q & ~sync3_q & {3{settle_q == 2'd3}};
`ifdef INT_NEST_EN
    eligible = pending_q & above_mask(in_service_q);
`else
    eligible = (in_service_q == 3'b000) ? pending_q : 3'b000;
`endif
    candidate = ie ? top_bit(eligible) : 3'b000;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    state_d  = state_q;
    irs_d    = irs_q;
    cnt_d    = cnt_q;
    pend_clr = 3'b000;
    is_set   = 3'b000;
    unique case (state_q)
      ST_IDLE: begin
        if (candidate != 3'b000) begin
          irs_d   = candidate;
          state_d = ST_ENTER;
        end
      end
      ST_ENTER: begin
        if (en) begin
          pend_clr = irs_q;
          is_set   = irs_q;
          cnt_d    = GUARD_LOAD;
          state_d  = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    int_enter_d = (state_d == ST_ENTER);
  end

  // A rise on the edge that clears the same bit must survive: set wins.
  always_comb begin
    pending_d    = (pending_q & ~pend_clr) | rise;
    in_service_d = in_service_q;
    if (uret) in_service_d = in_service_q & ~top_bit(in_service_q);
    in_service_d = in_service_d | is_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      irs_q        <= 3'b000;
      cnt_q        <= 4'd0;
      int_enter_q  <= 1'b0;
      pending_q    <= 3'b000;
      in_service_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      irs_q        <= irs_d;
      cnt_q        <= cnt_d;
      int_enter_q  <= int_enter_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  logic [WIDTH-1:0] idx_w;

  always_comb begin
    idx_w   = WIDTH'(onehot_idx(irs_q));
    int_vec = VEC_BASE + idx_w * VEC_STRIDE;
  end

  assign Int_Enter  = int_enter_q;
  assign IRS        = irs_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_int_req_ctrl.sv
// Directed bench for int_req_ctrl: latency, priority, nesting, stall, ie gating,
// set/clear collision and asynchronous reset, against hand-computed values.
module tb_int_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq;
  logic        ie;
  logic        en;
  logic        uret;
  logic        Int_Enter;
  logic [2:0]  IRS;
  logic [31:0] int_vec;
  logic [2:0]  pending;
  logic [2:0]  in_service;

  int n_checks = 0;
  int n_fail   = 0;

  int_req_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .ie         (ie),
    .en         (en),
    .uret       (uret),
    .Int_Enter  (Int_Enter),
    .IRS        (IRS),
    .int_vec    (int_vec),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    irq  = 3'b000;
    ie   = 1'b1;
    en   = 1'b1;
    uret = 1'b0;
    step(2);
    rst = 1'b0;
    step(4);
  endtask

  task automatic pulse_uret();
    uret = 1'b1;
    step(1);
    uret = 1'b0;
  endtask

  int hi;

  initial begin
    // Reset values
    do_reset();
    check("rst_enter",  32'(Int_Enter),  32'h0);
    check("rst_irs",    32'(IRS),        32'h0);
    check("rst_vec",    int_vec,         32'h100);
    check("rst_pend",   32'(pending),    32'h0);
    check("rst_insvc",  32'(in_service), 32'h0);

    // Single request on line 0: first sampled at edge 0
    irq = 3'b001;
    step(2);
    check("s_pend_e1",  32'(pending),    32'h0);
    step(1);
    check("s_pend_e2",  32'(pending),    32'h1);
    check("s_ent_e2",   32'(Int_Enter),  32'h0);
    step(1);
    check("s_ent_e3",   32'(Int_Enter),  32'h1);
    check("s_irs",      32'(IRS),        32'h1);
    check("s_vec",      int_vec,         32'h100);
    step(1);
    check("s_ent_e4",   32'(Int_Enter),  32'h0);
    check("s_insvc",    32'(in_service), 32'h1);
    check("s_pend_clr", 32'(pending),    32'h0);
    pulse_uret();
    check("s_uret",     32'(in_service), 32'h0);
    pulse_uret();
    check("s_uret_nop", 32'(in_service), 32'h0);

    // Priority: lines 0 and 2 rise together
    do_reset();
    irq = 3'b101;
    step(4);
    check("p_ent",      32'(Int_Enter),  32'h1);
    check("p_irs",      32'(IRS),        32'h4);
    check("p_vec",      int_vec,         32'h180);
    step(1);
    check("p_insvc",    32'(in_service), 32'h4);
    check("p_pend",     32'(pending),    32'h1);
    step(6);
    check("p_blocked",  32'(Int_Enter),  32'h0);
    check("p_irs_hold", 32'(IRS),        32'h4);
    pulse_uret();
    check("p_uret",     32'(in_service), 32'h0);
    step(1);
    check("p_ent0",     32'(Int_Enter),  32'h1);
    check("p_irs0",     32'(IRS),        32'h1);
    step(1);
    check("p_insvc0",   32'(in_service), 32'h1);
    check("p_pend0",    32'(pending),    32'h0);

    // Nesting: line 0 in service, line 1 rises
    step(6);
    irq = 3'b111;
    step(3);
    check("n_pend1",    32'(pending),    32'h2);
    step(1);
`ifdef INT_NEST_EN
    check("n_ent",      32'(Int_Enter),  32'h1);
    check("n_irs",      32'(IRS),        32'h2);
    check("n_vec",      int_vec,         32'h140);
    step(1);
    check("n_insvc",    32'(in_service), 32'h3);
    pulse_uret();
    check("n_uret1",    32'(in_service), 32'h1);
    step(1);
    pulse_uret();
    check("n_uret2",    32'(in_service), 32'h0);
`else
    check("n_noent",    32'(Int_Enter),  32'h0);
    check("n_insvc",    32'(in_service), 32'h1);
    pulse_uret();
    check("n_uret1",    32'(in_service), 32'h0);
    step(1);
    check("n_ent",      32'(Int_Enter),  32'h1);
    check("n_irs",      32'(IRS),        32'h2);
    check("n_vec",      int_vec,         32'h140);
    step(1);
    check("n_insvc1",   32'(in_service), 32'h2);
`endif

    // Stall: en low for 5 edges during ENTER, line 2 rises meanwhile
    do_reset();
    en  = 1'b0;
    irq = 3'b001;
    step(4);
    check("st_ent",     32'(Int_Enter),  32'h1);
    hi  = 1;
    irq = 3'b101;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (Int_Enter) hi++;
    end
    check("st_insvc",   32'(in_service), 32'h0);
    check("st_irs",     32'(IRS),        32'h1);
    check("st_pend",    32'(pending),    32'h5);
    en = 1'b1;
    step(1);
    if (Int_Enter) hi++;
    check("st_cycles",  32'(hi),         32'd6);
    check("st_insvc1",  32'(in_service), 32'h1);
    check("st_irs1",    32'(IRS),        32'h1);
    check("st_pend1",   32'(pending),    32'h4);

    // ie gating, then rise coincident with the clear of the same pending bit
    do_reset();
    ie  = 1'b0;
    en  = 1'b0;
    irq = 3'b010;
    step(6);
    check("ie_pend",    32'(pending),    32'h2);
    check("ie_noent",   32'(Int_Enter),  32'h0);
    ie = 1'b1;
    step(1);
    check("ie_ent",     32'(Int_Enter),  32'h1);
    check("ie_irs",     32'(IRS),        32'h2);
    irq = 3'b000;
    step(3);
    irq = 3'b010;
    step(2);
    en = 1'b1;
    step(1);
    check("col_pend",   32'(pending),    32'h2);
    check("col_insvc",  32'(in_service), 32'h2);
    check("col_ent",    32'(Int_Enter),  32'h0);

    // Asynchronous reset mid-ENTER; held line is not re-detected
    do_reset();
    irq = 3'b100;
    step(4);
    check("r_ent",      32'(Int_Enter),  32'h1);
    #2 rst = 1'b1;
    #1;
    check("r_ent0",     32'(Int_Enter),  32'h0);
    check("r_irs0",     32'(IRS),        32'h0);
    check("r_vec0",     int_vec,         32'h100);
    check("r_pend0",    32'(pending),    32'h0);
    check("r_insvc0",   32'(in_service), 32'h0);
    step(2);
    rst = 1'b0;
    step(10);
    check("r_noent",    32'(Int_Enter),  32'h0);
    check("r_nopend",   32'(pending),    32'h0);
    check("r_noinsvc",  32'(in_service), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_req_ctrl.md
# int_req_ctrl

Interrupt request controller: the producer side of the pipeline's interrupt-entry interface. Synchronises three external request lines, latches edges as pending requests and arbitrates them by fixed priority against the in-service set. It drives `Int_Enter` and the one-hot source `IRS` into the ID/EX stage, and retires in-service levels on `uret`. Sits beside the CSR file and feeds the ID-stage control path.

## Interface
- `WIDTH`, 32, datapath/vector width
- `VEC_BASE`, 32'h0000_0100, handler address of source 0
- `VEC_STRIDE`, 32'h0000_0040, address spacing between handlers
- `GUARD_CYCLES`, 4, post-entry cycles during which no new entry is issued (1..15)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `irq` in 3: raw request lines, asynchronous; bit 2 highest priority
- `ie` in 1: global interrupt enable from CSR
- `en` in 1: pipeline advance, same signal as the ID/EX register enable
- `uret` in 1: one-cycle pulse, uret retiring
- `Int_Enter` out 1: entry request to ID/EX (flushes that stage)
- `IRS` out 3: one-hot source of the current/last entry
- `int_vec` out WIDTH: handler address for `IRS`
- `pending` out 3: latched, unserviced requests
- `in_service` out 3: in-service levels

## Operation
- Per line: 2-flop synchroniser, then a third flop for edge detect; rise = sync2 & ~sync3. A rise sets `pending[i]`.
- Eligible source: highest-index `pending` bit whose index is above the highest set `in_service` bit (all eligible if `in_service`==0). Entry also requires `ie`=1.
- FSM has three states:
  - IDLE: if an eligible source exists, latch its one-hot value into `IRS` and go to ENTER.
  - ENTER: `Int_Enter`=1. On an edge with `en`=1: clear `pending[src]`, set `in_service[src]`, load guard counter with `GUARD_CYCLES`, and go to GUARD. With `en`=0, stay in ENTER. The selection does not change while in ENTER, even if a higher source arrives or `ie` drops.
  - GUARD: decrement the counter each cycle; go to IDLE after it reaches 0.
- `int_vec` = `VEC_BASE` + index(`IRS`)·`VEC_STRIDE`, computed mod 2^WIDTH. It is combinational from the registered `IRS`.
- `uret`=1 clears the highest set `in_service` bit. If `in_service`==0 it is ignored. It is honoured in every state.
- Simultaneous events:
  - Rise on the same cycle as the clear of that `pending` bit: set wins.
  - `uret` on the same edge as ENTER completion: first clear the highest pre-existing bit, then set the new bit.
- Re-entry of a source that is already in service is impossible, because the eligibility check is strict.

## Timing
- Reset values: `Int_Enter`=0, `IRS`=3'b000, `int_vec`=`VEC_BASE`, `pending`=0, `in_service`=0. FSM is in IDLE, counter 0, synchronisers 0.
- `irq[i]` first sampled high at edge k: `pending[i]`=1 after edge k+2, IDLE→ENTER at edge k+3, `Int_Enter`=1 from k+3. This is 3 cycles of minimum latency, given `ie`=1 and IDLE.
- `Int_Enter` is a registered Moore output. It stays high for exactly the ENTER duration: at least 1 cycle, extended by `en`=0 stalls.
- Minimum spacing between two entries is `GUARD_CYCLES`+2 cycles.
- Reset asserted mid-ENTER drops `Int_Enter` immediately (asynchronous) and discards pending requests. An `irq` still high after reset is not re-detected without a new rise.

## Configuration
- `INT_NEST_EN` defined: nesting enabled. A higher-priority source may enter while lower levels are in service (eligibility as above). `in_service` may hold up to 3 bits.
- `INT_NEST_EN` undefined: entry only when `in_service`==0. At most one `in_service` bit is ever set, and `uret` clears it.

## Test plan
- Single request: `irq`=3'b001 held from edge 0, `ie`=1, `en`=1 → `Int_Enter` high for 1 cycle at edge 3. Then `IRS`=001, `int_vec`=32'h100, `in_service`=001, `pending`=000.
- Priority: rises on lines 0 and 2 on the same edge → entry with `IRS`=100, `int_vec`=32'h180. After the guard, source 0 is not entered while bit 2 is in service and nesting applies. After `uret`, it enters with `in_service`=001.
- Nesting (macro defined): line 0 in service, then line 1 rises → entry; `in_service`=011. Two `uret` pulses leave 001, then 000. Without the macro: no entry until the first `uret`.
- Stall: `en`=0 for 5 cycles during ENTER → `Int_Enter` high for 6 cycles. `in_service` updates only on the `en`=1 edge. A line-2 rise during the stall does not change `IRS`.
- Edge cases:
  - `uret` with `in_service`=0 → no change.
  - `ie`=0 with line 1 pending → no entry; setting `ie`=1 → entry after 1 cycle.
  - Rise coincident with the clear of the same `pending` bit → that bit stays 1.
- Reset mid-ENTER → all outputs return to reset values asynchronously. `irq` held high afterwards produces no entry.
